// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial receiver.
//   state_t        : receiver frame FSM states
//   DATA_W_DEFAULT : default payload width in bits
package even_parity_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/even_parity_calc.sv
// Running XOR accumulator over a serial bit stream.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : fold d into the accumulator this cycle
//   d          : input bit
//   parity     : XOR of all bits folded in since the last clear
module even_parity_calc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic parity
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (clr) begin
      parity <= 1'b0;
    end else if (en) begin
      parity <= parity ^ d;
    end
  end

endmodule

// File: rtl/even_parity_rx_checker.sv
// Serial frame receiver with even-parity and framing checks.
// Frame: start(0), DATA_W data bits LSB first, even-parity bit, stop(1).
// Only cycles with bit_en=1 are samples of rx_bit.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bit_en     : sample strobe for rx_bit
//   rx_bit     : serial line, idle high
//   out_valid  : received word held until out_ready
//   out_ready  : consumer accepts the held word
//   out_data   : received payload
//   out_perr   : parity mismatch on the held word
//   out_ferr   : stop bit was 0 on the held word
//   overrun    : one-cycle pulse when a completed frame had to be dropped
module even_parity_rx_checker
  import even_parity_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_ferr,
  output logic              overrun
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              perr_q;
  logic              run_par;

  logic start_c;
  logic data_c;
  logic parity_c;
  logic stop_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-sample strobes; nothing moves without bit_en
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    data_c   = 1'b0;
    parity_c = 1'b0;
    stop_c   = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_bit) begin
            start_c = 1'b1;
            state_d = DATA;
          end
        end
        DATA: begin
          data_c = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_c = 1'b1;
          state_d  = STOP;
        end
        STOP: begin
          stop_c  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Running XOR of the data bits, cleared by the start bit
  even_parity_calc u_calc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_c),
    .en     (data_c),
    .d      (rx_bit),
    .parity (run_par)
  );

  // Frame assembly: LSB arrives first, so shift in from the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      perr_q    <= 1'b0;
    end else begin
      if (start_c) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (data_c) begin
        bit_cnt   <= bit_cnt + CNT_W'(1);
        shift_reg <= {rx_bit, shift_reg[DATA_W-1:1]};
      end
      if (parity_c) begin
        perr_q <= run_par ^ rx_bit;
      end
    end
  end

  // Output holding register; a new frame replaces the word only if the
  // slot is empty or being accepted this same cycle, otherwise it is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_perr  <= 1'b0;
      out_ferr  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (stop_c) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_data  <= shift_reg;
          out_perr  <= perr_q;
          out_ferr  <= ~rx_bit;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_even_parity_rx_checker.sv
module tb_even_parity_rx_checker;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          bit_en;
  logic          rx_bit;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_perr;
  logic          out_ferr;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int gap_max = 0;
  logic pre_stop_valid;

  even_parity_rx_checker #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .rx_bit    (rx_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_perr  (out_perr),
    .out_ferr  (out_ferr),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    logic          stop;
    logic          exp_perr;
    logic          exp_ferr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; optional idle gap with junk on rx_bit, then one sample
  task automatic send_bit(input logic b, input logic rdy);
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin
      bit_en = 1'b0;
      rx_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bit_en    = 1'b1;
    rx_bit    = b;
    out_ready = rdy;
    @(negedge clk);
    bit_en = 1'b0;
    rx_bit = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stp,
                            input logic rdy_at_stop);
    send_bit(1'b0, out_ready);
    for (int i = 0; i < int'(DW); i++) send_bit(d[i], out_ready);
    send_bit(par, out_ready);
    pre_stop_valid = out_valid;
    send_bit(stp, rdy_at_stop);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int pulses;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; bit_en = 1'b0; rx_bit = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_perr", 32'(out_perr), 0);
    chk("rst_ferr", 32'(out_ferr), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: each frame held with out_ready low, then accepted
    gap_max = 2;
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 1'b0);
      chk("pre_stop_valid", 32'(pre_stop_valid), 0);
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_data", 32'(out_data), 32'(vecs[i].data));
      chk("vec_perr", 32'(out_perr), 32'(vecs[i].exp_perr));
      chk("vec_ferr", 32'(out_ferr), 32'(vecs[i].exp_ferr));
      chk("vec_overrun", 32'(overrun), 0);
      repeat (2) @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(vecs[i].data));
      drain();
      chk("accept_clears", 32'(out_valid), 0);
    end

    // Overrun: second frame completes while first is still held
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    chk("ovr_first", 32'(out_data), 32'h11);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    chk("ovr_pulse", 32'(overrun), 1);
    chk("ovr_keep_data", 32'(out_data), 32'h11);
    chk("ovr_keep_valid", 32'(out_valid), 1);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (overrun) pulses++;
    end
    chk("ovr_single_pulse", 32'(pulses), 0);
    chk("ovr_still_11", 32'(out_data), 32'h11);
    drain();
    chk("ovr_drained", 32'(out_valid), 0);

    // Accept in the same cycle the next frame completes
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b0;
    chk("same_valid", 32'(out_valid), 1);
    chk("same_data", 32'(out_data), 32'h22);
    chk("same_overrun", 32'(overrun), 0);
    @(negedge clk);
    chk("same_hold", 32'(out_data), 32'h22);
    drain();

    // Back-to-back frames, no idle samples between them
    gap_max = 0;
    out_ready = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1, 1'b1);
    chk("b2b_first", 32'(out_data), 32'h81);
    send_frame(8'h42, 1'b0, 1'b1, 1'b1);
    chk("b2b_second", 32'(out_data), 32'h42);
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_overrun", 32'(overrun), 0);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in mid-frame while a word is held
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    @(negedge clk);
    chk("mid_rst_perr", 32'(out_perr), 0);
    chk("mid_rst_ferr", 32'(out_ferr), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    chk("no_partial_word", 32'(out_valid), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h5A);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_perr", 32'(out_perr), 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
